// File: rtl/assert_reporter_pkg.sv
// Shared types and constants for the assertion reporter: FSM state encoding,
// message kinds, ASCII bytes, message lengths and the hex digit helper.
package assert_reporter_pkg;

  // FSM state enumeration, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SEND_CHK  = 2'd1;
  localparam state_t ST_SEND_DONE = 2'd2;
  localparam state_t ST_HALT      = 2'd3;

  typedef enum logic [1:0] {
    MSG_OK   = 2'd0,
    MSG_FAIL = 2'd1,
    MSG_DONE = 2'd2
  } msg_t;

  localparam logic [7:0] ASC_O     = 8'h6F;
  localparam logic [7:0] ASC_K     = 8'h6B;
  localparam logic [7:0] ASC_F     = 8'h66;
  localparam logic [7:0] ASC_A     = 8'h61;
  localparam logic [7:0] ASC_I     = 8'h69;
  localparam logic [7:0] ASC_L     = 8'h6C;
  localparam logic [7:0] ASC_D     = 8'h64;
  localparam logic [7:0] ASC_N     = 8'h6E;
  localparam logic [7:0] ASC_E     = 8'h65;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam logic [3:0] LEN_OK   = 4'd7;
  localparam logic [3:0] LEN_FAIL = 4'd9;
  localparam logic [3:0] LEN_DONE = 4'd5;

  // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [3:0] msg_len(input msg_t kind);
    case (kind)
      MSG_OK:   return LEN_OK;
      MSG_FAIL: return LEN_FAIL;
      default:  return LEN_DONE;
    endcase
  endfunction

endpackage

// File: rtl/assert_reporter_msg.sv
// Combinational byte lookup: returns byte idx of the selected message, with the
// assertion id rendered as two uppercase hex digits.
module assert_reporter_msg
  import assert_reporter_pkg::*;
(
  input  msg_t        msg_type,
  input  logic [3:0]  idx,
  input  logic [7:0]  id,
  output logic [7:0]  data
);

  logic [7:0] hex_hi;
  logic [7:0] hex_lo;

  assign hex_hi = hex_ascii(id[7:4]);
  assign hex_lo = hex_ascii(id[3:0]);

  // NOTE: every path assigns data first, so no latch is inferred for
  // out-of-range indices.
  always_comb begin
    data = 8'h00;
    case (msg_type)
      MSG_OK: begin
        case (idx)
          4'd0:    data = ASC_O;
          4'd1:    data = ASC_K;
          4'd2:    data = ASC_COLON;
          4'd3:    data = ASC_SPACE;
          4'd4:    data = hex_hi;
          4'd5:    data = hex_lo;
          4'd6:    data = ASC_LF;
          default: data = 8'h00;
        endcase
      end
      MSG_FAIL: begin
        case (idx)
          4'd0:    data = ASC_F;
          4'd1:    data = ASC_A;
          4'd2:    data = ASC_I;
          4'd3:    data = ASC_L;
          4'd4:    data = ASC_COLON;
          4'd5:    data = ASC_SPACE;
          4'd6:    data = hex_hi;
          4'd7:    data = hex_lo;
          4'd8:    data = ASC_LF;
          default: data = 8'h00;
        endcase
      end
      MSG_DONE: begin
        case (idx)
          4'd0:    data = ASC_D;
          4'd1:    data = ASC_O;
          4'd2:    data = ASC_N;
          4'd3:    data = ASC_E;
          4'd4:    data = ASC_LF;
          default: data = 8'h00;
        endcase
      end
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/assert_reporter.sv
// Assertion reporter: accepts pass/fail check results, streams an ASCII line
// per check over a valid/ready byte port, and emits a final "done" line.
module assert_reporter
  import assert_reporter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CHK_VALID,
  output logic                   CHK_READY,
  input  logic                   CHK_PASS,
  input  logic [7:0]             CHK_ID,
  input  logic                   DONE_REQ,
  output logic [7:0]             TX_DATA,
  output logic                   TX_VALID,
  input  logic                   TX_READY,
  output logic [COUNT_WIDTH-1:0] PASS_COUNT,
  output logic [COUNT_WIDTH-1:0] FAIL_COUNT,
  output logic                   ALL_OK,
  output logic                   FINISHED,
  output logic                   EXIT_CODE
);

  state_t     state;
  msg_t       msg_type_q;
  logic [3:0] idx_q;
  logic [7:0] id_q;

  msg_t       lut_type;
  logic [3:0] lut_idx;
  logic [7:0] lut_id;
  logic [7:0] lut_data;
  logic       last_byte;

  // In IDLE the lookup prepares byte 0 of the incoming message; while sending
  // it prepares the byte after the one currently on TX_DATA.
  always_comb begin
    lut_type = msg_type_q;
    lut_idx  = idx_q + 4'd1;
    lut_id   = id_q;
    if (state == ST_IDLE) begin
      lut_idx = 4'd0;
      lut_id  = CHK_ID;
      if (!CHK_VALID)    lut_type = MSG_DONE;
      else if (CHK_PASS) lut_type = MSG_OK;
      else               lut_type = MSG_FAIL;
    end
  end

  assert_reporter_msg u_msg (
    .msg_type (lut_type),
    .idx      (lut_idx),
    .id       (lut_id),
    .data     (lut_data)
  );

  assign last_byte = (idx_q == msg_len(msg_type_q) - 4'd1);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      msg_type_q <= MSG_OK;
      idx_q      <= 4'd0;
      id_q       <= 8'h00;
      CHK_READY  <= 1'b0;
      TX_DATA    <= 8'h00;
      TX_VALID   <= 1'b0;
      PASS_COUNT <= '0;
      FAIL_COUNT <= '0;
      ALL_OK     <= 1'b1;
      FINISHED   <= 1'b0;
      EXIT_CODE  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!CHK_READY) begin
            CHK_READY <= 1'b1;
          end else if (CHK_VALID) begin
            // A pending check always wins over DONE_REQ.
            state      <= ST_SEND_CHK;
            msg_type_q <= lut_type;
            id_q       <= CHK_ID;
            idx_q      <= 4'd0;
            TX_DATA    <= lut_data;
            TX_VALID   <= 1'b1;
            CHK_READY  <= 1'b0;
            if (CHK_PASS) begin
              if (PASS_COUNT != '1) PASS_COUNT <= PASS_COUNT + COUNT_WIDTH'(1);
            end else begin
              if (FAIL_COUNT != '1) FAIL_COUNT <= FAIL_COUNT + COUNT_WIDTH'(1);
              ALL_OK <= 1'b0;
            end
          end else if (DONE_REQ) begin
            state      <= ST_SEND_DONE;
            msg_type_q <= MSG_DONE;
            idx_q      <= 4'd0;
            TX_DATA    <= lut_data;
            TX_VALID   <= 1'b1;
            CHK_READY  <= 1'b0;
          end
        end
        ST_SEND_CHK, ST_SEND_DONE: begin
          if (TX_READY) begin
            if (last_byte) begin
              TX_VALID <= 1'b0;
              if (state == ST_SEND_CHK) begin
                state     <= ST_IDLE;
                CHK_READY <= 1'b1;
              end else begin
                state     <= ST_HALT;
                FINISHED  <= 1'b1;
                EXIT_CODE <= !ALL_OK;
              end
            end else begin
              idx_q   <= idx_q + 4'd1;
              TX_DATA <= lut_data;
            end
          end
        end
        ST_HALT: begin
          CHK_READY <= 1'b0;
          TX_VALID  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          TX_VALID  <= 1'b0;
          CHK_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assert_reporter.sv
// Self-checking bench for assert_reporter: table-driven check messages plus
// hand-written sequences for done/halt, check-vs-done priority, mid-message
// reset, throughput and counter saturation.
module tb_assert_reporter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CHK_VALID = 1'b0;
  logic       CHK_PASS = 1'b0;
  logic [7:0] CHK_ID = 8'h00;
  logic       DONE_REQ = 1'b0;
  logic       TX_READY = 1'b1;

  logic        chk_ready, tx_valid, all_ok, finished, exit_code;
  logic [7:0]  tx_data;
  logic [15:0] pass_count, fail_count;

  logic        chk_ready2, tx_valid2, all_ok2, finished2, exit_code2;
  logic [7:0]  tx_data2;
  logic [1:0]  pass_count2, fail_count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assert_reporter #(.COUNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .CHK_VALID(CHK_VALID), .CHK_READY(chk_ready),
    .CHK_PASS(CHK_PASS), .CHK_ID(CHK_ID), .DONE_REQ(DONE_REQ),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(TX_READY),
    .PASS_COUNT(pass_count), .FAIL_COUNT(fail_count), .ALL_OK(all_ok),
    .FINISHED(finished), .EXIT_CODE(exit_code)
  );

  // Narrow-counter instance driven by the same stimulus for saturation.
  assert_reporter #(.COUNT_WIDTH(2)) dut_w2 (
    .CLK(CLK), .RST(RST), .CHK_VALID(CHK_VALID), .CHK_READY(chk_ready2),
    .CHK_PASS(CHK_PASS), .CHK_ID(CHK_ID), .DONE_REQ(DONE_REQ),
    .TX_DATA(tx_data2), .TX_VALID(tx_valid2), .TX_READY(TX_READY),
    .PASS_COUNT(pass_count2), .FAIL_COUNT(fail_count2), .ALL_OK(all_ok2),
    .FINISHED(finished2), .EXIT_CODE(exit_code2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [7:0]  id;
    logic        pass;
    int          mode;      // 0: TX_READY held high, 1: stall pattern
    int          len;
    logic [71:0] exp;       // expected bytes, first byte most significant
    int          exp_pass;
    int          exp_fail;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CHK_VALID = 1'b0;
    DONE_REQ = 1'b0;
    TX_READY = 1'b1;
    @(posedge CLK); #1;
    check("rst chk_ready", chk_ready, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst counts", {pass_count, fail_count}, 0);
    check("rst flags", {all_ok, finished, exit_code}, 3'b100);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post-rst chk_ready", chk_ready, 1);
  endtask

  // kind 0: check only, 1: check with DONE_REQ left high, 2: DONE_REQ only.
  task automatic issue(input string name, input int kind, input logic [7:0] id,
                       input logic pass, output int acc_cyc);
    int n = 0;
    while (!chk_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({name, " ready wait"}, chk_ready, 1);
    CHK_ID    = id;
    CHK_PASS  = pass;
    CHK_VALID = (kind != 2);
    DONE_REQ  = (kind != 0);
    @(posedge CLK);
    acc_cyc = cyc;
    #1;
    CHK_VALID = 1'b0;
    if (kind == 2) DONE_REQ = 1'b0;
    check({name, " latency"}, {tx_valid, chk_ready}, 2'b10);
  endtask

  task automatic collect(input string name, input logic [71:0] exp, input int len, input int mode);
    int         got_n = 0;
    int         guard = 0;
    int         ph = 0;
    logic       stall = 1'b0;
    logic       r;
    logic [7:0] held = 8'h00;
    while (got_n < len && guard < 300) begin
      @(negedge CLK);
      guard++;
      if (stall) check({name, " stall hold"}, {tx_valid, tx_data}, {1'b1, held});
      r = 1'b1;
      if (mode == 1) begin
        r = (ph % 4 == 0) || (ph % 4 == 3);
        if ($urandom_range(0, 3) == 0) r = ~r;
        ph++;
      end
      TX_READY = r;
      stall = tx_valid && !r;
      held  = tx_data;
      if (tx_valid && r) begin
        check($sformatf("%s byte%0d", name, got_n), tx_data, exp[8*(len-1-got_n) +: 8]);
        got_n++;
      end
    end
    check({name, " byte count"}, got_n, len);
    @(negedge CLK);
    TX_READY = 1'b1;
    check({name, " tx_valid after last"}, tx_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, prev_acc, viol;
    logic seen;

    vecs[0] = '{"pass 3A", 8'h3A, 1'b1, 0, 7, 72'h6F6B3A2033410A,   1, 0, 1'b1};
    vecs[1] = '{"fail F0", 8'hF0, 1'b0, 0, 9, 72'h6661696C3A2046300A, 1, 1, 1'b0};
    vecs[2] = '{"pass 05", 8'h05, 1'b1, 1, 7, 72'h6F6B3A2030350A,   2, 1, 1'b0};
    vecs[3] = '{"fail C7", 8'hC7, 1'b0, 1, 9, 72'h6661696C3A2043370A, 2, 2, 1'b0};

    do_reset();

    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].name, 0, vecs[i].id, vecs[i].pass, acc);
      collect(vecs[i].name, vecs[i].exp, vecs[i].len, vecs[i].mode);
      check({vecs[i].name, " pass_count"}, pass_count, vecs[i].exp_pass);
      check({vecs[i].name, " fail_count"}, fail_count, vecs[i].exp_fail);
      check({vecs[i].name, " all_ok"}, all_ok, vecs[i].exp_ok);
      check({vecs[i].name, " chk_ready"}, chk_ready, 1);
    end

    issue("done", 2, 8'h00, 1'b0, acc);
    collect("done", 72'h646F6E650A, 5, 0);
    check("done finished/exit", {finished, exit_code}, 2'b11);

    // HALT must ignore further checks and done requests.
    viol = 0;
    CHK_VALID = 1'b1;
    CHK_PASS  = 1'b1;
    DONE_REQ  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (chk_ready || tx_valid || pass_count != 16'd2 || fail_count != 16'd2 || !finished)
        viol++;
    end
    CHK_VALID = 1'b0;
    DONE_REQ  = 1'b0;
    check("halt absorbing violations", viol, 0);

    // Check and done offered together: check message first, then done.
    do_reset();
    issue("prio", 1, 8'h01, 1'b1, acc);
    collect("prio ok", 72'h6F6B3A2030310A, 7, 0);
    collect("prio done", 72'h646F6E650A, 5, 0);
    DONE_REQ = 1'b0;
    check("prio finished/exit", {finished, exit_code}, 2'b10);
    check("prio pass_count", pass_count, 1);

    // Reset after the third byte of a fail message aborts it.
    do_reset();
    issue("abort", 0, 8'h42, 1'b0, acc);
    repeat (3) @(posedge CLK);
    #1;
    check("abort pre-reset counts", {fail_count, 7'd0, all_ok}, {16'd1, 8'd0});
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort tx_valid", tx_valid, 0);
    check("abort counts", {pass_count, fail_count}, 0);
    check("abort all_ok", all_ok, 1);
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (tx_valid) seen = 1'b1;
    end
    check("abort no residual bytes", seen, 0);

    // Back-to-back passes: 8-cycle throughput and saturation of the 2-bit counters.
    do_reset();
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      issue("thru", 0, 8'h9B, 1'b1, acc);
      if (i > 0) check($sformatf("thru gap%0d", i), acc - prev_acc, 8);
      prev_acc = acc;
      collect("thru", 72'h6F6B3A2039420A, 7, 0);
      check($sformatf("thru pass_count%0d", i), pass_count, i + 1);
      check($sformatf("sat pass_count%0d", i), pass_count2, (i < 3) ? i + 1 : 3);
    end
    check("sat all_ok", all_ok2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assert_reporter.md
ASSERT_REPORTER -- requirements
Module: assert_reporter

Interface
REQ-001 Parameter: COUNT_WIDTH, 16, width of pass/fail counters.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CHK_VALID  input  1  check result offered.
REQ-005 CHK_READY  output  1  reporter accepts check this cycle.
REQ-006 CHK_PASS  input  1  1 = assertion passed, 0 = failed.
REQ-007 CHK_ID  input  8  assertion identifier.
REQ-008 DONE_REQ  input  1  level request to emit summary and finish.
REQ-009 TX_DATA  output  8  ASCII byte out.
REQ-010 TX_VALID  output  1  TX_DATA valid.
REQ-011 TX_READY  input  1  sink accepts byte.
REQ-012 PASS_COUNT, FAIL_COUNT  output  COUNT_WIDTH  accepted pass/fail totals.
REQ-013 ALL_OK  output  1  sticky; 0 once any failure accepted.
REQ-014 FINISHED  output  1  summary fully sent.
REQ-015 EXIT_CODE  output  1  equals !ALL_OK while FINISHED, else 0.

Function
REQ-016 FSM states IDLE, SEND_CHK, SEND_DONE, HALT; all outputs registered.
REQ-017 CHK_READY = 1 only in IDLE; check accepted when CHK_VALID && CHK_READY.
REQ-018 IDLE + accepted check -> SEND_CHK; id and pass latched; counter and ALL_OK update on the following edge.
REQ-019 IDLE, no CHK_VALID, DONE_REQ=1 -> SEND_DONE; CHK_VALID and DONE_REQ together: check wins, DONE_REQ is re-sampled after that message completes.
REQ-020 Pass message: "ok: HH" + LF (7 bytes); fail message: "fail: HH" + LF (9 bytes); HH = CHK_ID as two uppercase hex digits, high nibble first.
REQ-021 Done message: "done" + LF (5 bytes); after last byte accepted -> HALT, FINISHED=1.
REQ-022 First message byte presented with TX_VALID=1 on cycle after acceptance (latency 1).
REQ-023 Byte transfers on TX_VALID && TX_READY; TX_DATA and TX_VALID held stable while TX_READY=0.
REQ-024 After last byte transfers: TX_VALID=0 and return to IDLE (CHK_READY=1) next cycle; with TX_READY tied 1, pass throughput = one check per 8 cycles.
REQ-025 Counters saturate at all-ones; no wrap.
REQ-026 HALT absorbing until RST: CHK_READY=0, TX_VALID=0, counters frozen, further DONE_REQ ignored.
REQ-027 Bytes are never dropped, duplicated or reordered under arbitrary TX_READY back-pressure.

Reset
REQ-028 On RST: state IDLE, TX_VALID=0, TX_DATA=0, CHK_READY=0 during reset cycle then 1, counters 0, ALL_OK=1, FINISHED=0, EXIT_CODE=0.
REQ-029 RST mid-message aborts the message; no residual bytes emitted after reset.

Structure
REQ-030 Shared package holds: FSM state enum, ASCII constants (o,k,f,a,i,l,d,n,e,colon,space,LF), message length constants (7, 9, 5), nibble-to-ASCII hex function.
REQ-031 One sub-module assert_reporter_msg: combinational byte lookup from (message type, byte index, latched id).

Verification
REQ-032 Reset, one pass check CHK_ID=0x3A, TX_READY=1 -> bytes 6F 6B 3A 20 33 41 0A, PASS_COUNT=1, ALL_OK=1.
REQ-033 Fail check CHK_ID=0xF0 -> 66 61 69 6C 3A 20 46 30 0A, FAIL_COUNT=1, ALL_OK=0; then DONE_REQ -> 64 6F 6E 65 0A, FINISHED=1, EXIT_CODE=1.
REQ-034 TX_READY toggling 1-0-0-1 pseudo-randomly during pass check 0x05 -> identical 7-byte stream, TX_DATA stable on every stalled cycle.
REQ-035 CHK_VALID and DONE_REQ both high in IDLE with id 0x01 pass -> ok message first, then done message; EXIT_CODE=0.
REQ-036 RST asserted after third byte of a fail message -> TX_VALID=0 next cycle, counters 0, ALL_OK=1, no further bytes.
REQ-037 COUNT_WIDTH=2, five pass checks -> PASS_COUNT stays 3 after third.
